ace_snap_loader: RTL

ACE_SNAP_LOADER -- requirements
Module: ace_snap_loader

---
 rtl/ace_snap_loader_if.sv | 38 +++
 rtl/ace_snap_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ace_snap_loader_if.sv
// ace_snap_loader_if
//   Bundles the host download port (ioctl_*), the RAM write port (mem_*)
//   and the loader status outputs into one interface.
//
//   Handshake rules:
//     ioctl: a byte transfers in a cycle where ioctl_wr=1 and ioctl_wait=0.
//            A strobe seen while ioctl_wait=1 is dropped, not queued.
//     mem:   mem_wr is the valid and mem_ack the ready. While mem_wr=1,
//            mem_addr and mem_data stay stable until the cycle with mem_ack=1,
//            which completes that write.
//
//   Modports:
//     master - host/RAM side: drives ioctl_download, ioctl_wr, ioctl_dout, mem_ack
//     slave  - loader side:   drives ioctl_wait, mem_addr, mem_data, mem_wr,
//                             cpu_reset, done, err
interface ace_snap_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_wr;
  logic        mem_ack;
  logic        cpu_reset;
  logic        done;
  logic        err;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_dout, mem_ack,
    input  ioctl_wait, mem_addr, mem_data, mem_wr, cpu_reset, done, err
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_dout, mem_ack,
    output ioctl_wait, mem_addr, mem_data, mem_wr, cpu_reset, done, err
  );
endinterface

// File: rtl/ace_snap_loader.sv
// ace_snap_loader
//   Loads a run-length encoded .ACE snapshot streamed by the host into RAM.
//   Byte stream: any byte except ED is a literal; ED 00 ends the data; ED n v
//   writes v n times at consecutive addresses. The machine is held in reset
//   during the load and for RST_HOLD cycles afterwards, then done pulses.
//
// Ports:
//   clk_sys   - system clock, rising edge
//   reset     - synchronous active-high reset
//   bus       - ace_snap_loader_if.slave (ioctl download, RAM write, status)
//   dbg_state - current FSM state, for observation only
module ace_snap_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h2000,
  parameter logic [15:0] END_ADDR  = 16'h3FFF,
  parameter int          RST_HOLD  = 16
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  ace_snap_loader_if.slave        bus,
  output logic [2:0]              dbg_state
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LIT  = 3'd1;
  localparam logic [2:0] ST_ESC  = 3'd2;
  localparam logic [2:0] ST_CNT  = 3'd3;
  localparam logic [2:0] ST_RUN  = 3'd4;
  localparam logic [2:0] ST_SKIP = 3'd5;
  localparam logic [2:0] ST_HOLD = 3'd6;
  localparam logic [2:0] ST_WR   = 3'd7;

  localparam logic [7:0] ESC_BYTE = 8'hED;

  logic [2:0]  state;
  logic [15:0] addr;
  logic [7:0]  data;
  logic [7:0]  cnt;
  logic [15:0] hold_cnt;
  logic        dl_q;
  logic        ending;    // download fell while a write/run was in flight
  logic        err_r;
  logic        cpu_reset_r;
  logic        done_r;

  logic        dl_rise;
  logic        dl_fall;
  logic        busy;
  logic        in_range;
  logic        step;
  logic        accept;
  logic        ending_now;
  logic [2:0]  cur_state;
  logic        hold_last;

  assign dl_rise    = bus.ioctl_download & ~dl_q;
  assign dl_fall    = ~bus.ioctl_download & dl_q;
  assign busy       = (state == ST_WR) || (state == ST_RUN);
  assign in_range   = (addr <= END_ADDR);
  // An out-of-range element is consumed without a bus cycle, so it advances
  // on its own; an in-range one advances only on mem_ack.
  assign step       = ~in_range | bus.mem_ack;
  assign accept     = bus.ioctl_wr & ~busy & bus.ioctl_download;
  assign ending_now = ending | dl_fall;
  assign hold_last  = (32'(hold_cnt) + 32'd1 >= 32'(RST_HOLD));

  // A rising edge restarts from LIT in the same cycle, so a byte strobed
  // alongside the edge is decoded as the first byte of the new file.
  assign cur_state  = dl_rise ? ST_LIT : state;

  assign bus.ioctl_wait = busy;
  assign bus.mem_wr     = busy & in_range;
  assign bus.mem_addr   = addr;
  assign bus.mem_data   = data;
  assign bus.cpu_reset  = cpu_reset_r;
  assign bus.done       = done_r;
  assign bus.err        = err_r;
  assign dbg_state      = state;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= ST_IDLE;
      addr        <= BASE_ADDR;
      data        <= 8'h00;
      cnt         <= 8'h00;
      hold_cnt    <= 16'h0000;
      // Capturing the live level means a download already in progress when
      // reset releases is not mistaken for a new one.
      dl_q        <= bus.ioctl_download;
      ending      <= 1'b0;
      err_r       <= 1'b0;
      cpu_reset_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      dl_q   <= bus.ioctl_download;
      done_r <= 1'b0;

      if (dl_rise) begin
        addr        <= BASE_ADDR;
        err_r       <= 1'b0;
        cpu_reset_r <= 1'b1;
        ending      <= 1'b0;
        cnt         <= 8'h00;
        hold_cnt    <= 16'h0000;
        state       <= ST_LIT;
      end

      case (cur_state)
        ST_LIT: begin
          if (dl_fall) begin
            state <= ST_HOLD;
          end else if (accept) begin
            if (bus.ioctl_dout == ESC_BYTE) begin
              state <= ST_ESC;
            end else begin
              data  <= bus.ioctl_dout;
              state <= ST_WR;
            end
          end
        end

        ST_ESC: begin
          if (dl_fall) begin
            err_r <= 1'b1;
            state <= ST_HOLD;
          end else if (accept) begin
            if (bus.ioctl_dout == 8'h00) begin
              state <= ST_SKIP;
            end else begin
              cnt   <= bus.ioctl_dout;
              state <= ST_CNT;
            end
          end
        end

        ST_CNT: begin
          if (dl_fall) begin
            err_r <= 1'b1;
            state <= ST_HOLD;
          end else if (accept) begin
            data  <= bus.ioctl_dout;
            state <= ST_RUN;
          end
        end

        ST_SKIP: begin
          if (dl_fall) state <= ST_HOLD;
        end

        ST_WR: begin
          if (step) begin
            addr   <= addr + 16'd1;
            if (!in_range) err_r <= 1'b1;
            state  <= ending_now ? ST_HOLD : ST_LIT;
            ending <= 1'b0;
          end else if (dl_fall) begin
            ending <= 1'b1;
          end
        end

        ST_RUN: begin
          if (step) begin
            addr <= addr + 16'd1;
            cnt  <= cnt - 8'd1;
            if (!in_range) err_r <= 1'b1;
            if (cnt == 8'd1) begin
              state  <= ending_now ? ST_HOLD : ST_LIT;
              ending <= 1'b0;
            end else if (dl_fall) begin
              ending <= 1'b1;
            end
          end else if (dl_fall) begin
            ending <= 1'b1;
          end
        end

        ST_HOLD: begin
          if (hold_last) begin
            hold_cnt    <= 16'h0000;
            cpu_reset_r <= 1'b0;
            done_r      <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end

        default: begin
          // IDLE: a falling edge here belongs to a load already abandoned
          // by reset, so it is ignored.
        end
      endcase
    end
  end

endmodule
